// File: rtl/bit_serializer.sv
// Parallel-to-serial converter. It accepts a WIDTH-bit word through a load/ready
// handshake and emits the word one bit per clock on dout, qualified by
// dout_valid. A word accepted while the last bit is on the line follows it
// with no gap. word_cnt counts completed words and wraps modulo 256.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             done,
  output logic [7:0]       word_cnt
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             accept;

  // Move the register one place toward whichever end drives dout.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    if (MSB_FIRST)
      shift_one = {v[WIDTH-2:0], 1'b0};
    else
      shift_one = {1'b0, v[WIDTH-1:1]};
  endfunction

  // The counter holds the number of bits still to follow the one on dout.
  assign last   = (cnt == '0);
  assign accept = load && ready;

  // State register; reset returns to IDLE without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state: leave IDLE on accept; leave SHIFT only after the last bit with no reload.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: ready also opens on the last-bit cycle so the next word can follow gaplessly.
  always_comb begin
    ready      = 1'b1;
    dout       = 1'b0;
    dout_valid = 1'b0;
    done       = 1'b0;
    if (state == SHIFT) begin
      ready      = last;
      dout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
      dout_valid = 1'b1;
      done       = last;
    end
  end

  // Shift register and bit counter: load on accept, otherwise step through the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (accept) begin
      sreg <= data_in;
      cnt  <= CNT_LAST;
    end else if (state == SHIFT && !last) begin
      sreg <= shift_one(sreg);
      cnt  <= cnt - 1'b1;
    end
  end

  // Completed-word counter; bumps on the edge that retires the last bit, wrapping at 256.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      word_cnt <= '0;
    else if (state == SHIFT && last)
      word_cnt <= word_cnt + 8'd1;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share all
// inputs. Table-driven single-word vectors, then hand-written sequences for
// back-to-back, held-load, asynchronous reset and word counter wrap.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       load = 1'b0;

  logic       ready_m, dout_m, vld_m, done_m;
  logic [7:0] cnt_m;
  logic       ready_l, dout_l, vld_l, done_l;
  logic [7:0] cnt_l;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(ready_m), .dout(dout_m), .dout_valid(vld_m), .done(done_m), .word_cnt(cnt_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(ready_l), .dout(dout_l), .dout_valid(vld_l), .done(done_l), .word_cnt(cnt_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_m;  // bit 7 is the first bit on dout
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, " dout"}, dout_m, 0);
    chk({tag, " dout_valid"}, vld_m, 0);
    chk({tag, " done"}, done_m, 0);
    chk({tag, " ready"}, ready_m, 1);
    chk({tag, " word_cnt"}, cnt_m, exp_cnt[7:0]);
    chk({tag, " word_cnt_l"}, cnt_l, exp_cnt[7:0]);
  endtask

  // Accept one word from IDLE and check all eight bit cycles on both instances.
  task automatic run_word(input logic [7:0] d, input logic [7:0] em, input logic [7:0] el,
                          input string tag);
    data_in = d;
    load = 1'b1;
    tick();
    load = 1'b0;
    data_in = ~d;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s bit%0d dout_m", tag, k), dout_m, em[7-k]);
      chk($sformatf("%s bit%0d dout_l", tag, k), dout_l, el[7-k]);
      chk($sformatf("%s bit%0d valid", tag, k), vld_m, 1);
      chk($sformatf("%s bit%0d done", tag, k), done_m, (k == 7));
      chk($sformatf("%s bit%0d ready", tag, k), ready_m, (k == 7));
      tick();
    end
    exp_cnt++;
    idle_checks({tag, " after"});
  endtask

  initial begin
    vecs[0] = '{data: 8'hB6, exp_m: 8'b1011_0110, exp_l: 8'b0110_1101};
    vecs[1] = '{data: 8'h01, exp_m: 8'b0000_0001, exp_l: 8'b1000_0000};
    vecs[2] = '{data: 8'hC3, exp_m: 8'b1100_0011, exp_l: 8'b1100_0011};
    vecs[3] = '{data: 8'h2C, exp_m: 8'b0010_1100, exp_l: 8'b0011_0100};
    vecs[4] = '{data: 8'h80, exp_m: 8'b1000_0000, exp_l: 8'b0000_0001};

    // Reset state, released between edges; first edge afterwards can accept.
    #2;
    idle_checks("reset");
    @(negedge clk);
    rst = 1'b1;
    #4;

    // Single words from the table.
    for (int i = 0; i < 5; i++)
      run_word(vecs[i].data, vecs[i].exp_m, vecs[i].exp_l, $sformatf("vec%0d", i));

    // FF then 00 loaded in the done cycle: 16 gapless valid cycles.
    data_in = 8'hFF;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("b2b c%0d valid", k), vld_m, 1);
      chk($sformatf("b2b c%0d dout", k), dout_m, (k < 8));
      chk($sformatf("b2b c%0d done", k), done_m, (k == 7 || k == 15));
      if (k == 7) begin
        data_in = 8'h00;
        load = 1'b1;
      end
      tick();
      load = 1'b0;
    end
    exp_cnt += 2;
    idle_checks("b2b after");

    // Load held high with new data during B6: 0F taken only at the done edge.
    data_in = 8'hB6;
    load = 1'b1;
    tick();
    data_in = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("hold c%0d dout", k), dout_m, vecs[0].exp_m[7-k]);
      chk($sformatf("hold c%0d ready", k), ready_m, (k == 7));
      tick();
    end
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("hold2 c%0d valid", k), vld_m, 1);
      chk($sformatf("hold2 c%0d dout", k), dout_m, (k >= 4));
      tick();
    end
    exp_cnt += 2;
    idle_checks("hold after");

    // Asynchronous reset mid-word during bit 4.
    data_in = 8'hB6;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    tick();
    chk("arst pre valid", vld_m, 1);
    #2;
    rst = 1'b0;
    #1;
    exp_cnt = 0;
    idle_checks("arst during");
    #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("arst post c%0d valid", k), vld_m, 0);
    end
    chk("arst post word_cnt", cnt_m, 0);
    run_word(vecs[0].data, vecs[0].exp_m, vecs[0].exp_l, "arst reload");

    // Clear the counter, then 256 back-to-back words.
    #2;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    exp_cnt = 0;
    begin
      int gaps;
      gaps = 0;
      data_in = 8'hA5;
      load = 1'b1;
      tick();
      for (int w = 1; w <= 256; w++) begin
        for (int k = 0; k < 8; k++) begin
          if (vld_m !== 1'b1) gaps++;
          if (w == 256 && k == 7) load = 1'b0;
          tick();
        end
        if (w == 255) chk("wrap cnt 255", cnt_m, 8'd255);
        if (w == 256) chk("wrap cnt 0", cnt_m, 8'd0);
      end
      chk("wrap gaps", gaps, 0);
      chk("wrap end valid", vld_m, 0);
      chk("wrap end cnt_l", cnt_l, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means bit WIDTH-1 is sent first and 0 means bit 0 is sent first.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: the parallel word to serialize.
REQ-006 The block SHALL have port load, input, 1 bit: word-valid request.
REQ-007 The block SHALL have port ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 The block SHALL have port dout, output, 1 bit: the serial bit stream, feeding the downstream sequence detector's din.
REQ-009 The block SHALL have port dout_valid, output, 1 bit: dout carries a word bit this cycle.
REQ-010 The block SHALL have port done, output, 1 bit: dout carries the last bit of the current word.
REQ-011 The block SHALL have port word_cnt, output, 8 bits: count of completed words.

Function
REQ-012 The block SHALL implement exactly two states, IDLE and SHIFT, plus a WIDTH-bit shift register and a bit counter sized ceil(log2(WIDTH)).
REQ-013 Accept SHALL be defined as load=1 AND ready=1 at a rising clk edge; load with ready=0 SHALL be ignored, with no queuing.
REQ-014 ready SHALL be 1 in IDLE and 1 in SHIFT only when the bit counter is 0 (last bit), and 0 otherwise.
REQ-015 On accept the block SHALL capture data_in into the shift register, set the counter to WIDTH-1 and enter SHIFT.
REQ-016 In SHIFT, dout SHALL be the shift register MSB when MSB_FIRST=1, else its LSB, and dout_valid SHALL be 1.
REQ-017 On each SHIFT edge with counter>0, the block SHALL shift toward the output end by one and decrement the counter.
REQ-018 On the SHIFT edge with counter=0, the block SHALL increment word_cnt, then reload and stay in SHIFT if an accept occurs, else go to IDLE.
REQ-019 Latency SHALL be as follows: the first bit of an accepted word appears in the cycle immediately after the accept edge, and each word occupies exactly WIDTH consecutive dout_valid cycles.
REQ-020 Back-to-back operation: an accept during the last-bit cycle SHALL give a gapless stream, with dout_valid continuously 1.
REQ-021 done SHALL equal (state=SHIFT AND counter=0), a one-cycle pulse per word.
REQ-022 In IDLE, dout SHALL be 0, dout_valid 0 and done 0.
REQ-023 word_cnt SHALL wrap modulo 256 (255 -> 0) with no saturation or flag.
REQ-024 Changes on data_in outside an accept edge SHALL have no effect on dout.

Reset
REQ-025 rst=0 SHALL immediately, without waiting for clk, force state IDLE, shift register 0, counter 0 and word_cnt 0.
REQ-026 During reset the outputs SHALL be dout=0, dout_valid=0, done=0, ready=1 and word_cnt=0.
REQ-027 Reset asserted mid-word SHALL discard the partial word; no remaining bits are emitted, and word_cnt is not incremented.
REQ-028 After rst deasserts, the first rising edge SHALL already be able to accept a word.

Verification
REQ-029 The bench SHALL cover: WIDTH=8, MSB_FIRST=1, load 8'hB6 once -> dout 1,0,1,1,0,1,1,0 in cycles 1-8 after accept; dout_valid=1 for 8 cycles; done=1 in cycle 8 only; ready=0 in cycles 1-7; word_cnt 0->1.
REQ-030 The bench SHALL cover: MSB_FIRST=0, load 8'hB6 -> dout 0,1,1,0,1,1,0,1.
REQ-031 The bench SHALL cover: load 8'hFF, then 8'h00 asserted in the done cycle -> 16 contiguous dout_valid cycles of 1x8 followed by 0x8; word_cnt=2.
REQ-032 The bench SHALL cover: load held at 1 with a new data_in=8'h0F during cycles 2-7 of word 8'hB6 -> ignored; output is still the 8'hB6 pattern; 8'h0F is accepted only at the done edge.
REQ-033 The bench SHALL cover: rst=0 pulsed asynchronously between edges during bit 4 -> outputs clear within the same cycle; no further dout_valid; word_cnt=0; the next load is accepted normally.
REQ-034 The bench SHALL cover: 256 back-to-back words -> word_cnt reads 255 after the 255th word and 0 after the 256th.
